axi_perf_stats: RTL and testbench
=================================

Name: axi_perf_stats

Overview:
Passive per-channel AXI traffic monitor, parametrised in channel count and counter width, for the axi_perf_mem family of memory-benchmark designs. It snoops the AR/R/AW/W/B handshakes of NUM_CH manager ports and accumulates burst, beat, latency and busy-cycle statistics. A registered select/readout port lets a UART report engine dump results. It never drives AXI signals.

Parameters:
NUM_CH, 2, number of monitored AXI channels (1..8)
STAT_WIDTH, 16, width of every statistic counter
OUT_WIDTH, 4, width of per-channel read/write outstanding counters

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  statistics accumulate only while 1
clear  input  1  synchronous pulse, zeroes all statistics and error flags
arvalid, arready  input  NUM_CH each  per-channel AR handshake
rvalid, rready, rlast  input  NUM_CH each  per-channel R handshake
awvalid, awready  input  NUM_CH each  per-channel AW handshake
wvalid, wready  input  NUM_CH each  per-channel W handshake
bvalid, bready  input  NUM_CH each  per-channel B handshake
stat_ch  input  3  channel select for readout
stat_idx  input  3  statistic select for readout
stat_val  output  STAT_WIDTH  selected statistic, registered
err  output  NUM_CH  sticky protocol-error flag per channel

Behaviour:
- Reset (rst_n low, async): all statistics, outstanding counters, latency timers, stat_val and err are 0.
- Handshake = valid & ready in the same cycle, evaluated per channel independently.
- Statistics per channel, stat_idx: 0 rd_bursts (AR hs), 1 rd_beats (R hs), 2 wr_bursts (AW hs), 3 wr_beats (W hs), 4 rd_lat_max, 5 busy_cycles (cycles with rd_out!=0 or wr_out!=0, evaluated on pre-update values); idx 6,7 read 0.
- All statistic counters saturate at all-ones; they never wrap.
- Statistics update only when en=1. Outstanding counters and latency timer track protocol state regardless of en.
- clear has priority over any increment in the same cycle; zeroes statistics and err. It does not touch outstanding counters or an armed latency timer.
- rd_out: +1 on AR hs, -1 on R hs with rlast, unchanged when both fire. wr_out: +1 on AW hs, -1 on B hs, unchanged when both fire.
- Underflow (R-last or B hs with counter 0 and no simultaneous increment): counter stays 0, err[ch] set. Overflow at all-ones on increment: counter holds, err[ch] set.
- Latency: on AR hs with rd_out==0 (pre-update) and timer disarmed, timer loads 1 and arms. While armed it increments by 1 per cycle, saturating. On the first R hs while armed: rd_lat_max <= max(rd_lat_max, timer) if en; disarm. AR at cycle t, first R at t+3 -> latency 3. Bursts issued while another read is outstanding are not timed.
- R hs with rd_out==0 in the same cycle as the arming AR is a protocol error: err set, timer still arms.
- Readout: stat_val <= stat[stat_ch][stat_idx] on every clock, 1-cycle latency. stat_ch >= NUM_CH -> 0. Readout samples post-reset/pre-update register values, with no bypass.
- Reset asserted mid-burst: all state returns to 0 immediately. Traffic after release is treated as new.

Test Plan:
- Reset, en=1, ch0: 4 AR hs then 4 R bursts of 8 beats (rlast on 8th) -> rd_bursts=4, rd_beats=32, rd_out returns to 0, err=0.
- ch1: AR hs at cycle 10, first R hs at cycle 15; later AR at 30, R at 32 -> rd_lat_max=5; second AR while first outstanding is not timed.
- Simultaneous AR hs and R-last hs with rd_out=1 -> rd_out stays 1, rd_bursts+1; B hs with wr_out=0 -> err[ch]=1, wr_out=0.
- STAT_WIDTH=4, 20 W beats -> wr_beats=15 (saturated); clear pulse coincident with a W beat -> wr_beats=0, err=0.
- en=0 during 3 AW/B pairs -> wr_bursts unchanged, busy_cycles unchanged, wr_out back to 0; stat_ch=7 (NUM_CH=2) -> stat_val=0 one cycle later.
- Assert rst_n low with rd_out=3 and timer armed -> all outputs 0 immediately (asynchronous), stat_val=0 on release.

Source files
------------

// File: rtl/axi_perf_stats_if.sv
// Bundle of per-channel AXI handshake signals observed by the perf monitor.
// The master side drives everything; the monitor attaches through the slave
// modport, where every signal is an input.
interface axi_perf_stats_if #(
   parameter int NUM_CH = 2
);
   logic [NUM_CH-1:0] arvalid, arready;
   logic [NUM_CH-1:0] rvalid, rready, rlast;
   logic [NUM_CH-1:0] awvalid, awready;
   logic [NUM_CH-1:0] wvalid, wready;
   logic [NUM_CH-1:0] bvalid, bready;

   modport master (
      output arvalid, arready, rvalid, rready, rlast,
             awvalid, awready, wvalid, wready, bvalid, bready
   );

   modport slave (
      input  arvalid, arready, rvalid, rready, rlast,
             awvalid, awready, wvalid, wready, bvalid, bready
   );
endinterface

// File: rtl/axi_perf_stats.sv
// Passive AXI performance monitor: per-channel burst/beat/latency/busy
// statistics with sticky protocol-error flags and a registered readout port.

// Per-channel tracker: outstanding counters, read latency timer, statistics.
module axi_perf_stats_ch #(
   parameter int STAT_WIDTH = 16,
   parameter int OUT_WIDTH  = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic                           clear,
   input  logic                           ar_hs,
   input  logic                           r_hs,
   input  logic                           rlast,
   input  logic                           aw_hs,
   input  logic                           w_hs,
   input  logic                           b_hs,
   output logic [5:0][STAT_WIDTH-1:0]     stat,
   output logic                           err
);
   logic [OUT_WIDTH-1:0]           rd_out_q, rd_out_d;
   logic [OUT_WIDTH-1:0]           wr_out_q, wr_out_d;
   logic [STAT_WIDTH-1:0]          tmr_q, tmr_d;
   logic                           arm_q, arm_d;
   logic [5:0][STAT_WIDTH-1:0]     stat_q, stat_d;
   logic                           err_q, err_d;
   logic                           r_last_hs;
   logic                           lat_hit;
   logic                           err_set;
   logic                           busy;

   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign r_last_hs = r_hs & rlast;
   assign busy      = (|rd_out_q) | (|wr_out_q);

   // Protocol state: outstanding counters, latency timer and error detection
   always_comb begin
      rd_out_d = rd_out_q;
      wr_out_d = wr_out_q;
      tmr_d    = tmr_q;
      arm_d    = arm_q;
      lat_hit  = 1'b0;
      err_set  = 1'b0;

      // Simultaneous increment and decrement cancel out.
      if (ar_hs && !r_last_hs) begin
         if (&rd_out_q) err_set = 1'b1;
         else           rd_out_d = rd_out_q + 1'b1;
      end else if (r_last_hs && !ar_hs) begin
         if (rd_out_q == '0) err_set = 1'b1;
         else                rd_out_d = rd_out_q - 1'b1;
      end

      if (aw_hs && !b_hs) begin
         if (&wr_out_q) err_set = 1'b1;
         else           wr_out_d = wr_out_q + 1'b1;
      end else if (b_hs && !aw_hs) begin
         if (wr_out_q == '0) err_set = 1'b1;
         else                wr_out_d = wr_out_q - 1'b1;
      end

      // Only a burst issued onto an idle read path is timed.
      if (!arm_q && ar_hs && (rd_out_q == '0)) begin
         tmr_d = STAT_WIDTH'(1);
         arm_d = 1'b1;
         // Data cannot legally accompany the address that starts the read.
         if (r_hs) err_set = 1'b1;
      end else if (arm_q) begin
         if (r_hs) begin
            arm_d   = 1'b0;
            lat_hit = 1'b1;
         end else begin
            tmr_d = sat_inc(tmr_q);
         end
      end

      err_d = clear ? 1'b0 : (err_q | err_set);
   end

   // Statistic accumulation; clear wins over any increment
   always_comb begin
      stat_d = stat_q;
      if (clear) begin
         stat_d = '0;
      end else if (en) begin
         if (ar_hs) stat_d[0] = sat_inc(stat_q[0]);
         if (r_hs)  stat_d[1] = sat_inc(stat_q[1]);
         if (aw_hs) stat_d[2] = sat_inc(stat_q[2]);
         if (w_hs)  stat_d[3] = sat_inc(stat_q[3]);
         if (lat_hit && (tmr_q > stat_q[4])) stat_d[4] = tmr_q;
         if (busy)  stat_d[5] = sat_inc(stat_q[5]);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_out_q <= '0;
         wr_out_q <= '0;
         tmr_q    <= '0;
         arm_q    <= 1'b0;
         stat_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_out_q <= rd_out_d;
         wr_out_q <= wr_out_d;
         tmr_q    <= tmr_d;
         arm_q    <= arm_d;
         stat_q   <= stat_d;
         err_q    <= err_d;
      end
   end

   assign stat = stat_q;
   assign err  = err_q;
endmodule

// Top: one tracker per channel plus the registered statistic mux.
module axi_perf_stats #(
   parameter int NUM_CH     = 2,
   parameter int STAT_WIDTH = 16,
   parameter int OUT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  clear,
   axi_perf_stats_if.slave       bus,
   input  logic [2:0]            stat_ch,
   input  logic [2:0]            stat_idx,
   output logic [STAT_WIDTH-1:0] stat_val,
   output logic [NUM_CH-1:0]     err
);
   logic [NUM_CH-1:0][5:0][STAT_WIDTH-1:0] ch_stat;
   logic [NUM_CH-1:0]                      ch_err;
   logic [STAT_WIDTH-1:0]                  stat_val_q, stat_val_d;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      axi_perf_stats_ch #(
         .STAT_WIDTH (STAT_WIDTH),
         .OUT_WIDTH  (OUT_WIDTH)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .clear (clear),
         .ar_hs (bus.arvalid[g] & bus.arready[g]),
         .r_hs  (bus.rvalid[g]  & bus.rready[g]),
         .rlast (bus.rlast[g]),
         .aw_hs (bus.awvalid[g] & bus.awready[g]),
         .w_hs  (bus.wvalid[g]  & bus.wready[g]),
         .b_hs  (bus.bvalid[g]  & bus.bready[g]),
         .stat  (ch_stat[g]),
         .err   (ch_err[g])
      );
   end

   // Readout mux: absent channels and indices 6/7 read as zero
   always_comb begin
      stat_val_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if ((stat_ch == 3'(c)) && (stat_idx < 3'd6)) stat_val_d = ch_stat[c][stat_idx];
      end
   end

   // Readout register, sampled from pre-update statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stat_val_q <= '0;
      else        stat_val_q <= stat_val_d;
   end

   assign stat_val = stat_val_q;
   assign err      = ch_err;
endmodule

// File: tb/tb_axi_perf_stats.sv
// Randomized and directed check of axi_perf_stats against a timestamp-based
// behavioural model of the monitored traffic.
module tb_axi_perf_stats;
   localparam int NCH  = 2;
   localparam int SW   = 5;
   localparam int OW   = 3;
   localparam int SMAX = (1 << SW) - 1;
   localparam int OMAX = (1 << OW) - 1;
   localparam int AR = 0, R = 1, AW = 2, W = 3, B = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           en, clear;
   logic [2:0]     stat_ch, stat_idx;
   logic [SW-1:0]  stat_val;
   logic [NCH-1:0] err;

   axi_perf_stats_if #(.NUM_CH(NCH)) bus ();

   axi_perf_stats #(.NUM_CH(NCH), .STAT_WIDTH(SW), .OUT_WIDTH(OW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .bus(bus),
      .stat_ch(stat_ch), .stat_idx(stat_idx), .stat_val(stat_val), .err(err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int           m_st [NCH][6];
   int           m_rd [NCH];
   int           m_wr [NCH];
   bit           m_arm [NCH];
   int           m_t0 [NCH];
   bit [NCH-1:0] m_err;
   int           m_cyc;
   int           exp_val;

   function automatic int sat(input int v);
      return (v >= SMAX) ? SMAX : v + 1;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         for (int i = 0; i < 6; i++) m_st[c][i] = 0;
         m_rd[c] = 0; m_wr[c] = 0; m_arm[c] = 0; m_t0[c] = 0;
      end
      m_err = '0;
      exp_val = 0;
   endtask

   task automatic model_step();
      bit arh, rh, rlh, awh, wh, bh, e, busy;
      int lat;
      if (int'(stat_ch) < NCH && int'(stat_idx) < 6) exp_val = m_st[stat_ch][stat_idx];
      else                                           exp_val = 0;
      for (int c = 0; c < NCH; c++) begin
         arh = bus.arvalid[c] & bus.arready[c];
         rh  = bus.rvalid[c]  & bus.rready[c];
         rlh = rh & bus.rlast[c];
         awh = bus.awvalid[c] & bus.awready[c];
         wh  = bus.wvalid[c]  & bus.wready[c];
         bh  = bus.bvalid[c]  & bus.bready[c];
         e    = 0;
         busy = (m_rd[c] != 0) || (m_wr[c] != 0);
         lat  = -1;
         if (!m_arm[c] && arh && m_rd[c] == 0) begin
            m_arm[c] = 1; m_t0[c] = m_cyc;
            if (rh) e = 1;
         end else if (m_arm[c] && rh) begin
            lat = (m_cyc - m_t0[c] > SMAX) ? SMAX : m_cyc - m_t0[c];
            m_arm[c] = 0;
         end
         if (arh && !rlh) begin
            if (m_rd[c] == OMAX) e = 1; else m_rd[c]++;
         end else if (rlh && !arh) begin
            if (m_rd[c] == 0) e = 1; else m_rd[c]--;
         end
         if (awh && !bh) begin
            if (m_wr[c] == OMAX) e = 1; else m_wr[c]++;
         end else if (bh && !awh) begin
            if (m_wr[c] == 0) e = 1; else m_wr[c]--;
         end
         if (clear) begin
            for (int i = 0; i < 6; i++) m_st[c][i] = 0;
         end else if (en) begin
            if (arh) m_st[c][0] = sat(m_st[c][0]);
            if (rh)  m_st[c][1] = sat(m_st[c][1]);
            if (awh) m_st[c][2] = sat(m_st[c][2]);
            if (wh)  m_st[c][3] = sat(m_st[c][3]);
            if (lat > m_st[c][4]) m_st[c][4] = lat;
            if (busy) m_st[c][5] = sat(m_st[c][5]);
         end
         m_err[c] = clear ? 1'b0 : (m_err[c] | e);
      end
      m_cyc++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Per-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      check("stat_val", 32'(stat_val), 32'(exp_val));
      check("err", 32'(err), 32'(m_err));
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      bus.arvalid = '0; bus.arready = '0;
      bus.rvalid  = '0; bus.rready  = '0; bus.rlast = '0;
      bus.awvalid = '0; bus.awready = '0;
      bus.wvalid  = '0; bus.wready  = '0;
      bus.bvalid  = '0; bus.bready  = '0;
   endtask

   task automatic set_hs(input int ch, input int kind, input bit last);
      case (kind)
         AR: begin bus.arvalid[ch] = 1'b1; bus.arready[ch] = 1'b1; end
         R:  begin bus.rvalid[ch] = 1'b1; bus.rready[ch] = 1'b1; bus.rlast[ch] = last; end
         AW: begin bus.awvalid[ch] = 1'b1; bus.awready[ch] = 1'b1; end
         W:  begin bus.wvalid[ch] = 1'b1; bus.wready[ch] = 1'b1; end
         default: begin bus.bvalid[ch] = 1'b1; bus.bready[ch] = 1'b1; end
      endcase
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic one(input int ch, input int kind, input bit last);
      idle(); set_hs(ch, kind, last); nclk(1); idle();
   endtask

   task automatic rd_pin(input int ch, input int idx, input int exp, input string nm);
      idle();
      stat_ch = 3'(ch); stat_idx = 3'(idx);
      nclk(1);
      check(nm, 32'(stat_val), 32'(exp));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0; en = 1'b0; clear = 1'b0;
      stat_ch = '0; stat_idx = '0;
      idle();
      nclk(3);
      rst_n = 1'b1;
      check("reset_stat_val", 32'(stat_val), 0);
      check("reset_err", 32'(err), 0);
      en = 1'b1;

      // four reads on ch0, 8 beats each; 32 beats saturate a 5-bit counter
      repeat (4) one(0, AR, 0);
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 8; k++) one(0, R, k == 7);
      rd_pin(0, 0, 4,  "ch0_rd_bursts");
      rd_pin(0, 1, 31, "ch0_rd_beats_sat");
      rd_pin(0, 4, 4,  "ch0_rd_lat_max");
      check("ch0_err_clean", 32'(err), 0);

      // ch1 latency: 5, then 2, then a pair where only the first is timed
      one(1, AR, 0); nclk(4); one(1, R, 1);
      one(1, AR, 0); nclk(1); one(1, R, 1);
      one(1, AR, 0); one(1, AR, 0); one(1, R, 1); nclk(6); one(1, R, 1);
      rd_pin(1, 4, 5, "ch1_rd_lat_max");
      rd_pin(1, 0, 4, "ch1_rd_bursts");

      // AR and R-last together with one outstanding; B underflow on ch1
      one(0, AR, 0);
      idle(); set_hs(0, AR, 0); set_hs(0, R, 1); nclk(1);
      one(1, B, 0);
      one(0, R, 1);
      rd_pin(0, 0, 6, "ch0_rd_bursts_sim");
      check("err_b_underflow", 32'(err), 2);

      // clear, then saturate W beats, then clear coincident with a W beat
      clear = 1'b1; nclk(1); clear = 1'b0;
      check("err_after_clear", 32'(err), 0);
      repeat (40) one(0, W, 0);
      rd_pin(0, 3, 31, "ch0_wr_beats_sat");
      idle(); set_hs(0, W, 0); clear = 1'b1; nclk(1); clear = 1'b0;
      rd_pin(0, 3, 0, "ch0_wr_beats_clr");

      // write pair with en=1, then three with en=0
      one(1, AW, 0); one(1, B, 0);
      en = 1'b0;
      repeat (3) begin one(1, AW, 0); one(1, B, 0); end
      en = 1'b1;
      nclk(3);
      rd_pin(1, 2, 1, "ch1_wr_bursts_en");
      rd_pin(1, 5, 1, "ch1_busy_en");
      rd_pin(7, 0, 0, "absent_channel");
      rd_pin(0, 6, 0, "idx6_zero");

      // async reset with reads outstanding and timer armed
      one(1, B, 0);
      repeat (3) one(0, AR, 0);
      rd_pin(0, 0, 3, "ch0_rd_bursts_pre_rst");
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_stat_val", 32'(stat_val), 0);
      check("async_rst_err", 32'(err), 0);
      @(negedge clk); rst_n = 1'b1;
      rd_pin(0, 0, 0, "post_rst_stat_val");
      nclk(3);
      rd_pin(0, 5, 0, "post_rst_busy");

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         bus.arvalid = NCH'($urandom); bus.arready = NCH'($urandom);
         bus.rvalid  = NCH'($urandom); bus.rready  = NCH'($urandom);
         bus.rlast   = NCH'($urandom);
         bus.awvalid = NCH'($urandom); bus.awready = NCH'($urandom);
         bus.wvalid  = NCH'($urandom); bus.wready  = NCH'($urandom);
         bus.bvalid  = NCH'($urandom); bus.bready  = NCH'($urandom);
         en       = ($urandom % 16) != 0;
         clear    = ($urandom % 64) == 0;
         stat_ch  = 3'($urandom);
         stat_idx = 3'($urandom);
         if (i == 2000) begin
            #2 rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
         end else begin
            nclk(1);
         end
      end
      idle(); clear = 1'b0; en = 1'b1;
      nclk(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
